inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//   Parametrised, decoupled instruction-fetch stage for the pipelined MIPS core; replaces the
//   combinational PC/Add_PC/Instruction_Memory path of the single-cycle CPU. Owns the PC, issues
//   pipelined requests to a variable-latency instruction memory and buffers returned words with
//   their PCs in a DEPTH-entry queue. Presents them to decode over a valid/ready handshake and
//   flushes cleanly on branch/jump redirect.
// PARAMETERS
//   ADDR_W    32   PC / memory address width
//   INST_W    32   instruction word width
//   DEPTH     4    queue entries = max (buffered + in-flight) fetches; power of 2, >= 2
//   RESET_PC  0    PC value after reset
//   PC_STEP   4    sequential PC increment
// PORTS
//   clk_i          in   1       clock, rising edge
//   rst_i          in   1       synchronous, active-high reset
//   start_i        in   1       begin fetching (sampled; sticky once seen)
//   imem_req_o     out  1       fetch request valid
//   imem_addr_o    out  ADDR_W  fetch address (= PC)
//   imem_gnt_i     in   1       request accepted this cycle (req && gnt = issue)
//   imem_rvalid_i  in   1       response valid; responses return in issue order
//   imem_rdata_i   in   INST_W  response instruction
//   inst_valid_o   out  1       head instruction valid to decode
//   inst_o         out  INST_W  head instruction
//   inst_pc_o      out  ADDR_W  PC of head instruction
//   inst_ready_i   in   1       decode accepts head (valid && ready = pop)
//   redirect_i     in   1       branch/jump taken: flush and restart
//   redirect_pc_i  in   ADDR_W  new fetch PC
// BEHAVIOUR
//   - Reset: state=IDLE, pc=RESET_PC, queue empty, drop_cnt=0; imem_req_o=0, inst_valid_o=0,
//     imem_addr_o=RESET_PC, inst_o=0, inst_pc_o=0.
//   - FSM IDLE->RUN when start_i=1 (first request the following cycle); RUN exits only on reset.
//   - imem_req_o = RUN && free_entries>0 (registered state only; no comb path from imem_*_i).
//   - Issue: allocate tail entry {pc, filled=0}; pc <= pc+PC_STEP (mod 2^ADDR_W, wraps silently).
//   - Response (rvalid): if drop_cnt>0, discard and drop_cnt--; else fill oldest unfilled entry.
//   - inst_valid_o = head entry allocated && filled; min latency rvalid->inst_valid_o = 1 cycle.
//   - Pop frees head; pop and fill/issue may coincide; full queue with pop allows issue same cycle
//     only from next cycle (credit counted on registered occupancy).
//   - Redirect (highest priority): pc <= redirect_pc_i; all entries cleared; drop_cnt <= number of
//     issued-but-unreturned fetches after this cycle's gnt/rvalid (a same-cycle issue is dropped).
//     A same-cycle pop still completes (decode has consumed it). inst_valid_o=0 next cycle.
//   - Redirect while drop_cnt>0 accumulates: drop_cnt <= drop_cnt + new unreturned count.
//   - Redirect in IDLE only loads pc. rvalid with no outstanding fetch = protocol error (assert).
//   - Queue never overflows: allocated + drop_cnt <= DEPTH invariant (assert).
// STRUCTURE
//   - cpu_pkg: ADDR_W/INST_W defaults, RESET_PC, PC_STEP, fetch FSM state enum {IDLE,RUN}.
//   - Sub-module fetch_queue: circular buffer with alloc/fill/pop pointers, filled bits, flush.
//   - Top: FSM, PC register, request gating, drop counter.
// TESTING
//   1 Reset, start_i=1, gnt=1, 1-cycle rvalid -> PCs 0,4,8,.. to decode back-to-back, no bubbles.
//   2 inst_ready_i=0 -> exactly DEPTH=4 issues (0..12), imem_req_o=0; release -> issue resumes at 16.
//   3 Memory latency 3 with 2 in flight, redirect to 0x100 -> 2 stale rdata discarded;
//     first inst_pc_o=0x100 with word returned for 0x100.
//   4 Redirect same cycle as gnt and pop -> popped inst consumed once, granted fetch dropped,
//     drop_cnt counts it.
//   5 pc=0xFFFFFFFC sequential -> next fetch address 0x0 (wrap).
//   6 rst_i asserted mid-stream with fetches in flight -> all outputs reset next cycle, IDLE until start_i.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared defaults and the fetch-stage state type for the pipelined core front end.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INST_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam int unsigned RESET_PC_DEF = 0;
    localparam int unsigned PC_STEP_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: slots are allocated at issue, filled on response, popped by decode.
// Fill-to-head-valid is one cycle; flush clears every slot in the same cycle.
module fetch_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alloc_i,
    input  logic [ADDR_W-1:0]        alloc_pc_i,
    input  logic                     fill_i,
    input  logic [INST_W-1:0]        fill_dat_i,
    input  logic                     pop_i,
    output logic                     head_vld_o,
    output logic [INST_W-1:0]        head_inst_o,
    output logic [ADDR_W-1:0]        head_pc_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   unfilled_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       head_q, fill_q, tail_q;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else begin
            if (alloc_i) tail_q <= tail_q + 1'b1;
            if (fill_i)  fill_q <= fill_q + 1'b1;
            if (pop_i)   head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_i && !flush_i) pc_mem_q[tail_q[AW-1:0]]   <= alloc_pc_i;
        if (fill_i && !flush_i)  inst_mem_q[fill_q[AW-1:0]] <= fill_dat_i;
    end

    assign head_vld_o  = (head_q != fill_q);
    assign head_inst_o = head_vld_o ? inst_mem_q[head_q[AW-1:0]] : '0;
    assign head_pc_o   = head_vld_o ? pc_mem_q[head_q[AW-1:0]]   : '0;
    assign count_o     = tail_q - head_q;
    assign unfilled_o  = tail_q - fill_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled instruction fetch: owns the PC, pipelines requests to imem, queues words for decode.
// rvalid->inst_valid_o in 1 cycle; requests stall when buffered + in-flight fetches reach DEPTH.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter int unsigned       DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     count, unfilled, occupied, outstanding;
    logic              run, issue, resp_fill, resp_drop, pop, flush;

    assign run         = (state_q == RUN);
    assign occupied    = count + drop_q;
    assign outstanding = drop_q + unfilled;
    assign imem_req_o  = run && (occupied < CW'(DEPTH));
    assign imem_addr_o = pc_q;
    assign issue       = imem_req_o && imem_gnt_i;
    assign resp_drop   = imem_rvalid_i && (drop_q != '0);
    assign resp_fill   = imem_rvalid_i && (drop_q == '0);
    assign pop         = inst_valid_o && inst_ready_i;
    assign flush       = run && redirect_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (start_i)    state_d = RUN;
                if (redirect_i) pc_d    = redirect_pc_i;
            end
            RUN: begin
                if (redirect_i) begin
                    // Everything still owed by memory after this cycle becomes stale.
                    pc_d   = redirect_pc_i;
                    drop_d = outstanding + CW'(issue) - CW'(imem_rvalid_i);
                end else begin
                    if (issue)     pc_d   = pc_q + ADDR_W'(PC_STEP);
                    if (resp_drop) drop_d = drop_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush),
        .alloc_i     (issue),
        .alloc_pc_i  (pc_q),
        .fill_i      (resp_fill),
        .fill_dat_i  (imem_rdata_i),
        .pop_i       (pop),
        .head_vld_o  (inst_valid_o),
        .head_inst_o (inst_o),
        .head_pc_o   (inst_pc_o),
        .count_o     (count),
        .unfilled_o  (unfilled)
    );

    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && (outstanding == '0)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        occupied <= CW'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i, inst_o, inst_pc_o, redirect_pc_i;
    logic        inst_valid_o, inst_ready_i, redirect_i;

    inst_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_ready_i(inst_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } resp_t;

    int          total = 0, bad = 0, cyc = 0, n_issue = 0, n_pop = 0, last_due = 0;
    int          gnt_mode = 1, rdy_mode = 1, lat_fix = 1;
    logic        start_req = 0, rst_req = 1, redir_req = 0, prev_redir = 0;
    logic [31:0] redir_tgt = 0;
    logic [31:0] fetch_pc = 0, exp_pc = 0;
    logic [31:0] last_issue_addr = 0, prev_issue_addr = 0, last_pop_pc = 0, last_pop_inst = 0;
    resp_t       rq[$];

    // Memory contents: a bijective function of the address, so every word identifies its PC.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // One clock: drive at negedge, check the fetch-stream model, advance model after posedge.
    task automatic cycle();
        logic s_issue, s_pop, s_rv;
        logic [31:0] s_addr, s_pc, s_inst;
        int lat, due;
        @(negedge clk_i);
        rst_i         = rst_req;
        start_i       = start_req;
        redirect_i    = redir_req;
        redirect_pc_i = redir_tgt;
        imem_gnt_i    = rst_req ? 1'b0 : (gnt_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(gnt_mode));
        inst_ready_i  = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
        s_rv          = !rst_req && rq.size() > 0 && rq[0].due <= cyc;
        imem_rvalid_i = s_rv;
        imem_rdata_i  = s_rv ? rq[0].dat : $urandom;
        #1;
        s_issue = imem_req_o && imem_gnt_i && !rst_req;
        s_pop   = inst_valid_o && inst_ready_i && !rst_req;
        s_addr  = imem_addr_o;
        s_pc    = inst_pc_o;
        s_inst  = inst_o;
        if (prev_redir) begin
            total++;
            if (inst_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL valid_after_redirect got=%b want=0", inst_valid_o);
            end
        end
        if (s_issue) begin
            total++;
            if (s_addr !== fetch_pc) begin
                bad++;
                $display("FAIL issue_addr got=%h want=%h", s_addr, fetch_pc);
            end
        end
        if (s_pop) begin
            total += 2;
            if (s_pc !== exp_pc) begin
                bad++;
                $display("FAIL pop_pc got=%h want=%h", s_pc, exp_pc);
            end
            if (s_inst !== memf(exp_pc)) begin
                bad++;
                $display("FAIL pop_inst got=%h want=%h", s_inst, memf(exp_pc));
            end
        end
        @(posedge clk_i);
        cyc++;
        prev_redir = redir_req && !rst_req;
        if (rst_req) begin
            fetch_pc = 0;
            exp_pc   = 0;
            last_due = 0;
            rq.delete();
        end else begin
            if (s_rv) void'(rq.pop_front());
            if (s_issue) begin
                lat = lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4));
                due = cyc + lat - 1;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq.push_back('{memf(s_addr), due});
                n_issue++;
                prev_issue_addr = last_issue_addr;
                last_issue_addr = s_addr;
            end
            if (s_pop) begin
                n_pop++;
                last_pop_pc   = s_pc;
                last_pop_inst = s_inst;
            end
            if (redir_req) begin
                fetch_pc = redir_tgt;
                exp_pc   = redir_tgt;
            end else begin
                if (s_issue) fetch_pc = fetch_pc + 32'd4;
                if (s_pop)   exp_pc   = exp_pc + 32'd4;
            end
        end
        redir_req = 1'b0;
    endtask

    task automatic reset_and_start();
        rst_req = 1'b1;
        repeat (2) cycle();
        rst_req   = 1'b0;
        start_req = 1'b1;
        cycle();
        start_req = 1'b0;
    endtask

    task automatic wait_pop(input int base, input string name);
        int k;
        k = 0;
        while (n_pop == base && k < 40) begin
            cycle();
            k++;
        end
        if (n_pop == base) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_pop want=pop", name);
        end
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        repeat (2) cycle();
        rst_req = 1'b0;
        #1;
        total += 5;
        if (imem_req_o !== 1'b0)    begin bad++; $display("FAIL rst_req got=%b want=0", imem_req_o); end
        if (inst_valid_o !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid_o); end
        if (imem_addr_o !== 32'h0)  begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr_o); end
        if (inst_o !== 32'h0)       begin bad++; $display("FAIL rst_inst got=%h want=0", inst_o); end
        if (inst_pc_o !== 32'h0)    begin bad++; $display("FAIL rst_pc got=%h want=0", inst_pc_o); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                redir_req = 1'b1;
                redir_tgt = 32'h40;
            end
            cycle();
            #1;
            total++;
            if (imem_req_o !== 1'b0) begin bad++; $display("FAIL idle_req got=%b want=0", imem_req_o); end
        end
        start_req = 1'b1;
        cycle();
        start_req = 1'b0;
        #1;
        total += 2;
        if (imem_req_o !== 1'b1)     begin bad++; $display("FAIL start_req got=%b want=1", imem_req_o); end
        if (imem_addr_o !== 32'h40)  begin bad++; $display("FAIL idle_redirect_pc got=%h want=40", imem_addr_o); end
    endtask

    task automatic test_stream();
        int p0;
        gnt_mode = 1; rdy_mode = 1; lat_fix = 1;
        reset_and_start();
        wait_pop(n_pop, "stream_first");
        total++;
        if (last_pop_pc !== 32'h0) begin bad++; $display("FAIL stream_first_pc got=%h want=0", last_pop_pc); end
        p0 = n_pop;
        repeat (20) cycle();
        total++;
        if (n_pop - p0 != 20) begin bad++; $display("FAIL stream_bubbles got=%0d want=20", n_pop - p0); end
    endtask

    task automatic test_backpressure();
        int i0, k;
        gnt_mode = 1; rdy_mode = 0; lat_fix = 1;
        reset_and_start();
        i0 = n_issue;
        repeat (12) cycle();
        #1;
        total += 2;
        if (n_issue - i0 != 4)   begin bad++; $display("FAIL bp_issues got=%0d want=4", n_issue - i0); end
        if (imem_req_o !== 1'b0) begin bad++; $display("FAIL bp_req got=%b want=0", imem_req_o); end
        rdy_mode = 1;
        i0 = n_issue;
        k = 0;
        while (n_issue == i0 && k < 10) begin
            cycle();
            k++;
        end
        total++;
        if (n_issue == i0 || last_issue_addr !== 32'h10) begin
            bad++;
            $display("FAIL bp_resume_addr got=%h want=10", last_issue_addr);
        end
        repeat (10) cycle();
    endtask

    task automatic test_redirect_latency();
        int k, p0;
        gnt_mode = 1; rdy_mode = 1; lat_fix = 3;
        reset_and_start();
        k = n_issue;
        while (n_issue < k + 2) cycle();
        gnt_mode  = 0;
        redir_req = 1'b1;
        redir_tgt = 32'h100;
        total++;
        if (rq.size() != 2) begin bad++; $display("FAIL lat_inflight got=%0d want=2", rq.size()); end
        cycle();
        gnt_mode = 1;
        p0 = n_pop;
        wait_pop(p0, "lat_first");
        total += 2;
        if (last_pop_pc !== 32'h100)         begin bad++; $display("FAIL lat_first_pc got=%h want=100", last_pop_pc); end
        if (last_pop_inst !== memf(32'h100)) begin bad++; $display("FAIL lat_first_inst got=%h want=%h", last_pop_inst, memf(32'h100)); end
        repeat (15) cycle();
    endtask

    task automatic test_redirect_collision();
        int i0, p0;
        gnt_mode = 1; rdy_mode = 1; lat_fix = 1;
        reset_and_start();
        repeat (8) cycle();
        #1;
        total++;
        if (!(imem_req_o === 1'b1 && inst_valid_o === 1'b1)) begin
            bad++;
            $display("FAIL coll_setup got=req%b/vld%b want=req1/vld1", imem_req_o, inst_valid_o);
        end
        i0 = n_issue;
        p0 = n_pop;
        redir_req = 1'b1;
        redir_tgt = 32'h200;
        cycle();
        total++;
        if (n_issue - i0 != 1 || n_pop - p0 != 1) begin
            bad++;
            $display("FAIL coll_events got=issue%0d/pop%0d want=issue1/pop1", n_issue - i0, n_pop - p0);
        end
        p0 = n_pop;
        wait_pop(p0, "coll_first");
        total++;
        if (last_pop_pc !== 32'h200) begin bad++; $display("FAIL coll_first_pc got=%h want=200", last_pop_pc); end
        // Back-to-back redirects while stale fetches are still owed.
        lat_fix = 4;
        repeat (4) cycle();
        redir_req = 1'b1; redir_tgt = 32'h300;
        cycle();
        cycle();
        redir_req = 1'b1; redir_tgt = 32'h400;
        cycle();
        p0 = n_pop;
        wait_pop(p0, "accum_first");
        total++;
        if (last_pop_pc !== 32'h400) begin bad++; $display("FAIL accum_first_pc got=%h want=400", last_pop_pc); end
        repeat (10) cycle();
    endtask

    task automatic test_wrap();
        int i0, k;
        logic seen;
        gnt_mode = 1; rdy_mode = 1; lat_fix = 1;
        reset_and_start();
        repeat (5) cycle();
        redir_req = 1'b1;
        redir_tgt = 32'hFFFF_FFF8;
        cycle();
        i0   = n_issue;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 20) begin
            cycle();
            k++;
            if (n_issue > i0 && last_issue_addr == 32'h0) seen = 1'b1;
        end
        total++;
        if (!seen || prev_issue_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap got=seen%b/prev%h want=seen1/prev=fffffffc", seen, prev_issue_addr);
        end
        repeat (10) cycle();
    endtask

    task automatic test_random();
        gnt_mode = 2; rdy_mode = 2; lat_fix = 0;
        reset_and_start();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                redir_req = 1'b1;
                redir_tgt = $urandom & 32'hFFFF_FFFC;
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        gnt_mode = 1; rdy_mode = 1; lat_fix = 3;
        repeat (6) cycle();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        #1;
        total += 5;
        if (imem_req_o !== 1'b0)   begin bad++; $display("FAIL mid_rst_req got=%b want=0", imem_req_o); end
        if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", inst_valid_o); end
        if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL mid_rst_addr got=%h want=0", imem_addr_o); end
        if (inst_o !== 32'h0)      begin bad++; $display("FAIL mid_rst_inst got=%h want=0", inst_o); end
        if (inst_pc_o !== 32'h0)   begin bad++; $display("FAIL mid_rst_pc got=%h want=0", inst_pc_o); end
        repeat (3) begin
            cycle();
            #1;
            total++;
            if (imem_req_o !== 1'b0) begin bad++; $display("FAIL mid_idle_req got=%b want=0", imem_req_o); end
        end
        start_req = 1'b1;
        cycle();
        start_req = 1'b0;
        p0 = n_pop;
        wait_pop(p0, "mid_first");
        total++;
        if (last_pop_pc !== 32'h0) begin bad++; $display("FAIL mid_first_pc got=%h want=0", last_pop_pc); end
        repeat (10) cycle();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        imem_rdata_i = '0; inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collision();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
